// File: rtl/source2_pkg.sv
// Shared definitions for the two-phase req/ack source: state encoding and a clog2 helper.
`ifndef SOURCE2_PKG_SV
`define SOURCE2_PKG_SV

package source2_pkg;

  typedef enum logic [1:0] {
    GAP_WAIT = 2'd0,
    LAUNCH   = 2'd1,
    PENDING  = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >>> 1;
    end
    return result;
  endfunction

endpackage

`endif

// File: rtl/source2.sv
// Two-phase (toggle) req/ack packet source emitting an incrementing word sequence.
// Define SOURCE2_LOG_EN to print a line per launch and when done rises.
module source2
  import source2_pkg::*;
#(
  parameter int ID    = 0,
  parameter int SIZE  = 8,
  parameter int COUNT = 4,
  parameter int GAP   = 0,
  parameter int START = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ack,
  output logic            req,
  output logic [SIZE-1:0] data,
  output logic            done
);

  localparam int CNT_W = (clog2(COUNT + 1) < 1) ? 1 : clog2(COUNT + 1);
  localparam int GAP_W = (clog2(GAP + 1) < 1) ? 1 : clog2(GAP + 1);
  localparam logic [SIZE-1:0]  START_VAL  = SIZE'(START);
  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(COUNT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP - 1);

  state_t           state;
  logic [CNT_W-1:0] sent;
  logic [GAP_W-1:0] gap_cnt;

  // The completion edge itself counts as the first idle cycle, so the
  // per-transfer period is exactly 2 + GAP with a single-register sink.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req     <= 1'b0;
      data    <= START_VAL;
      done    <= 1'b0;
      sent    <= '0;
      gap_cnt <= '0;
      state   <= (GAP == 0) ? LAUNCH : GAP_WAIT;
    end else begin
      case (state)
        GAP_WAIT: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= LAUNCH;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        LAUNCH: begin
          req   <= ~req;
          state <= PENDING;
        end
        PENDING: begin
          if (ack == req) begin
            if (sent != '1) sent <= sent + 1'b1;
            data <= data + 1'b1;
            if (COUNT != 0 && sent == COUNT_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else if (GAP == 0) begin
              req <= ~req;
            end else if (GAP == 1) begin
              state <= LAUNCH;
            end else begin
              gap_cnt <= GAP_W'(1);
              state   <= GAP_WAIT;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= GAP_WAIT;
        end
      endcase
    end
  end

`ifdef SOURCE2_LOG_EN
  // Every req toggle out of reset is a launch; data already holds its word.
  always @(req) begin
    if (!reset) $display("%0t: Source %0d: data %h", $time, ID, data);
  end

  always @(posedge done) begin
    $display("%0t: Source %0d: done", $time, ID);
  end
`else
  logic unused_id;
  assign unused_id = ^ID;
`endif

endmodule

// File: tb/tb_source2.sv
// Self-checking bench for source2: closed-form timeline model plus directed stall/reset tests.
module tb_source2;

  localparam int MODEL_EDGES = 620;

  typedef struct packed {
    logic       req;
    logic [7:0] data;
    logic       done;
  } exp_t;

  logic       clk;
  logic       rst_main;
  logic       rst4;
  logic [4:0] ack_q;
  logic       sink_en4;
  logic       ack4_manual;
  logic       ack4;
  logic       model_on;
  logic       model_done;

  logic       req0, req1, req2, req3, req4;
  logic       done0, done1, done2, done3, done4;
  logic [7:0] d0, d1, d2, d3, d4;

  int checks = 0;
  int errors = 0;

  int tog0[$];
  int dat0[$];
  int tog1[$];
  int dat1[$];
  int dat2[$];
  int done_edge0 = -1;
  int done_edge1 = -1;
  int recv0 = 0;
  int tog3_count = 0;
  int data3_599 = -1;

  assign ack4 = sink_en4 ? ack_q[4] : ack4_manual;

  source2 #(.ID(0), .SIZE(8), .COUNT(4), .GAP(0), .START(0)) u0 (
    .clk(clk), .reset(rst_main), .ack(ack_q[0]), .req(req0), .data(d0), .done(done0));
  source2 #(.ID(1), .SIZE(8), .COUNT(2), .GAP(3), .START(16)) u1 (
    .clk(clk), .reset(rst_main), .ack(ack_q[1]), .req(req1), .data(d1), .done(done1));
  source2 #(.ID(2), .SIZE(8), .COUNT(3), .GAP(0), .START(254)) u2 (
    .clk(clk), .reset(rst_main), .ack(ack_q[2]), .req(req2), .data(d2), .done(done2));
  source2 #(.ID(3), .SIZE(8), .COUNT(0), .GAP(0), .START(0)) u3 (
    .clk(clk), .reset(rst_main), .ack(ack_q[3]), .req(req3), .data(d3), .done(done3));
  source2 #(.ID(4), .SIZE(8), .COUNT(4), .GAP(0), .START(0)) u4 (
    .clk(clk), .reset(rst4), .ack(ack4), .req(req4), .data(d4), .done(done4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transfer i launches at edge GAP + i*(2+GAP) and completes two edges later.
  function automatic exp_t model(input int gap, input int count, input int start, input int e);
    int launched;
    int completed;
    exp_t x;
    launched  = (e < gap) ? 0 : (e - gap) / (2 + gap) + 1;
    completed = (e < gap + 2) ? 0 : (e - gap - 2) / (2 + gap) + 1;
    if (count != 0 && launched > count) launched = count;
    if (count != 0 && completed > count) completed = count;
    x.req  = launched[0];
    x.data = 8'(start + completed);
    x.done = (count != 0) && (completed >= count);
    return x;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareInst(input string tag, input logic r, input logic [7:0] d,
                             input logic dn, input exp_t x);
    checkOutput({tag, "_req"}, int'(r), int'(x.req));
    checkOutput({tag, "_data"}, int'(d), int'(x.data));
    checkOutput({tag, "_done"}, int'(dn), int'(x.done));
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic manual_ack);
    rst4        = rst;
    sink_en4    = en;
    ack4_manual = manual_ack;
  endtask

  // Single-register two-phase sink per instance: ack follows req one edge later.
  initial begin : sink
    logic [4:0] s;
    ack_q = '0;
    forever begin
      @(negedge clk);
      s = {req4, req3, req2, req1, req0};
      @(posedge clk);
      #1;
      ack_q = s & ~{rst4, {4{rst_main}}};
    end
  end

  initial begin : compare
    logic [3:0] prev_req;
    logic       prev_ack0;
    exp_t       x;
    model_done = 1'b0;
    @(posedge model_on);
    prev_req  = '0;
    prev_ack0 = 1'b0;
    for (int e = 0; e < MODEL_EDGES; e++) begin
      @(negedge clk);
      x = model(0, 4, 0, e);
      compareInst("u0", req0, d0, done0, x);
      x = model(3, 2, 16, e);
      compareInst("u1", req1, d1, done1, x);
      x = model(0, 3, 254, e);
      compareInst("u2", req2, d2, done2, x);
      x = model(0, 0, 0, e);
      compareInst("u3", req3, d3, done3, x);

      if (req0 != prev_req[0]) begin tog0.push_back(e); dat0.push_back(int'(d0)); end
      if (req1 != prev_req[1]) begin tog1.push_back(e); dat1.push_back(int'(d1)); end
      if (req2 != prev_req[2]) dat2.push_back(int'(d2));
      if (req3 != prev_req[3] && e < 600) tog3_count++;
      if (e == 599) data3_599 = int'(d3);
      if (done0 && done_edge0 < 0) done_edge0 = e;
      if (done1 && done_edge1 < 0) done_edge1 = e;
      if (ack_q[0] != prev_ack0) recv0++;
      prev_req  = {req3, req2, req1, req0};
      prev_ack0 = ack_q[0];
    end
    model_done = 1'b1;
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int exp2[3];
    exp2 = '{254, 255, 0};
    model_on = 1'b0;
    rst_main = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    #2;
    checkOutput("reset_async_u0_req", int'(req0), 0);
    checkOutput("reset_async_u2_data", int'(d2), 254);
    repeat (3) @(negedge clk);

    checkOutput("reset_u0_req", int'(req0), 0);
    checkOutput("reset_u0_data", int'(d0), 0);
    checkOutput("reset_u0_done", int'(done0), 0);
    checkOutput("reset_u1_data", int'(d1), 16);
    checkOutput("reset_u2_data", int'(d2), 254);
    checkOutput("reset_u4_req", int'(req4), 0);

    rst_main = 1'b0;
    model_on = 1'b1;
    wait (model_done == 1'b1);

    checkOutput("u0_toggle_count", tog0.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("u0_toggle_edge", (i < tog0.size()) ? tog0[i] : -1, 2 * i);
      checkOutput("u0_launch_data", (i < dat0.size()) ? dat0[i] : -1, i);
    end
    checkOutput("u0_done_edge", done_edge0, 8);
    checkOutput("u0_receptions", recv0, 4);

    checkOutput("u1_toggle_count", tog1.size(), 2);
    for (int i = 0; i < 2; i++) begin
      checkOutput("u1_toggle_edge", (i < tog1.size()) ? tog1[i] : -1, 3 + 5 * i);
      checkOutput("u1_launch_data", (i < dat1.size()) ? dat1[i] : -1, 16 + i);
    end
    checkOutput("u1_done_edge", done_edge1, 10);

    checkOutput("u2_launch_count", dat2.size(), 3);
    for (int i = 0; i < 3; i++)
      checkOutput("u2_launch_data", (i < dat2.size()) ? dat2[i] : -1, exp2[i]);
    checkOutput("u2_done_final", int'(done2), 1);
    checkOutput("u2_data_final", int'(d2), 1);

    checkOutput("u3_toggles_600", tog3_count, 300);
    checkOutput("u3_data_e599", data3_599, 43);
    checkOutput("u3_done_never", int'(done3), 0);

    // Stall: ack withheld, transfer 0 held pending for 20 cycles.
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("u4_first_launch_req", int'(req4), 1);
    repeat (20) begin
      @(negedge clk);
      checkOutput("u4_stall_req", int'(req4), 1);
      checkOutput("u4_stall_data", int'(d4), 0);
      checkOutput("u4_stall_done", int'(done4), 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("u4_release_data", int'(d4), 1);
    checkOutput("u4_release_req", int'(req4), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("u4_second_data", int'(d4), 2);
    checkOutput("u4_second_req", int'(req4), 1);

    // Reset while pending with req=1, ack=0: outputs must clear without a clock edge.
    #2;
    applyStimulus(1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("u4_midreset_req", int'(req4), 0);
    checkOutput("u4_midreset_data", int'(d4), 0);
    checkOutput("u4_midreset_done", int'(done4), 0);
    repeat (3) @(negedge clk);

    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("u4_restart_req", int'(req4), 1);
    checkOutput("u4_restart_data", int'(d4), 0);
    repeat (2) @(negedge clk);
    checkOutput("u4_restart_data_e2", int'(d4), 1);
    repeat (6) @(negedge clk);
    checkOutput("u4_restart_done", int'(done4), 1);
    checkOutput("u4_restart_final_data", int'(d4), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/source2.md
Name: source2

Overview:
- Packet-generating source for the two-phase (toggle) req/ack channel used by the sink stages in the simpnoc test fabric.
- Sits directly upstream of a two-phase sink: drives data plus a toggling req, and waits for the matching ack toggle.
- Emits a deterministic incrementing word sequence with a programmable inter-transfer gap and a total transfer count, then raises done.
- Used to load sinks and routers in directed tests.

Parameters:
- ID, 0, instance number, used only in log messages.
- SIZE, 8, data width in bits.
- COUNT, 4, number of transfers to send; 0 means unlimited (done never asserts).
- GAP, 0, idle cycles inserted between a transfer's completion and the next req toggle.
- START, 0, first data value sent (truncated to SIZE bits).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- ack  input  1  two-phase acknowledge from downstream; a transfer completes when ack equals req.
- req  output  1  two-phase request; each toggle offers one word.
- data  output  SIZE  word offered; stable while req != ack.
- done  output  1  high once COUNT transfers have completed; sticky until reset.

Behaviour:
- Reset (async, clock-independent) sets:
  - req = 0, data = START, done = 0.
  - sent counter = 0, gap counter = 0.
  - state = GAP_WAIT, or LAUNCH if GAP == 0.
- Handshake rules:
  - Pending when req != ack; complete when ack == req.
  - ack is sampled on posedge clk without a synchroniser (same clock domain).
- States:
  - GAP_WAIT: gap counter increments each cycle. When it reaches GAP-1, go to LAUNCH on the next edge and clear the counter.
  - LAUNCH: toggle req on this edge; data already holds the word to send; go to PENDING.
  - PENDING: hold req and data. On the edge where ack == req:
    - sent counter increments and data <= data + 1, wrapping mod 2^SIZE (0xFF -> 0x00 for SIZE=8).
    - If sent counter + 1 == COUNT (COUNT != 0): go to DONE and set done = 1 on the same edge.
    - Else if GAP == 0: toggle req on the same edge (back-to-back) and stay in PENDING.
    - Else: go to GAP_WAIT.
  - DONE: req and data frozen, ack ignored, done held at 1.
- Timing:
  - First req toggle occurs GAP cycles after reset release.
  - With a single-register sink downstream, a transfer completes 2 edges after the req toggle.
  - Peak throughput with GAP=0 is one word per 2 cycles.
  - Per-transfer period = 2 + GAP cycles.
- Data changes only on a completion edge, never while a transfer is pending.
- Sent counter width is clog2(COUNT+1), with a minimum of 1. When COUNT == 0 the counter saturates and does not wrap into done.
- Spurious ack toggle outside PENDING (ack != req in GAP_WAIT or DONE): no state change, and no transfer is counted. The next launch still toggles req as normal, leaving req == ack; this is treated as an immediate completion. This is documented protocol-violation behaviour.
- Reset asserted mid-transfer: everything returns to reset values at once; any in-flight word is abandoned.

Optional Feature:
- Macro SOURCE2_LOG_EN.
- When defined, each launch prints the time, "Source", ID and the data value in the same format as the sink's log line. A "done" line prints when done rises.
- When undefined, there are no $display calls and logic is identical.
- The feature must not change cycle behaviour.

Decomposition:
- Shared package/header (include-guarded) holds the state encoding constants: GAP_WAIT=2'd0, LAUNCH=2'd1, PENDING=2'd2, DONE=2'd3.
- It also holds a clog2 function reused by other stages.
- Single module; no sub-module is required. The gap counter is inline.

Test Plan:
- COUNT=4, GAP=0, START=0, SIZE=8 into a two-phase sink:
  - req toggles at edges 0, 2, 4 and 6 after reset release.
  - data goes 0, 1, 2, 3.
  - done rises at edge 8.
  - Exactly 4 sink receptions.
- GAP=3, COUNT=2, START=0x10:
  - First req toggle 3 cycles after reset.
  - Second toggle 3 cycles after the first completion.
  - data 0x10 then 0x11; period 5 cycles.
- START=0xFE, COUNT=3, SIZE=8 -> data sequence 0xFE, 0xFF, 0x00 (wrap); done=1.
- ack withheld for 20 cycles in PENDING -> req, data and sent count stable throughout. Releasing ack completes the transfer on the next edge.
- Reset asserted while PENDING (req=1, ack=0):
  - Outputs return immediately to req=0, data=START, done=0.
  - After release, the sequence restarts from START.
- COUNT=0, GAP=0, run 600 cycles -> 300 transfers, data wraps past 0xFF, done stays 0.
